// File: rtl/ntt_poly_mem_server.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ntt_poly_mem_server
// Purpose  : Memory-side responder for an NTT core's address/data port.
//            Holds the input polynomial (inbuf) that the core reads and the
//            result polynomial (outbuf) that the core writes. Loads inbuf
//            from a host valid/ready stream, raises ntt_start, waits for the
//            core's finish edge, then streams outbuf back out in address
//            order.
// Ports    : clk, rst (async, active-low)
//            s_valid/s_ready/s_data           host load stream
//            m_valid/m_ready/m_data/m_last    host unload stream
//            ntt_start, ntt_read_address, ntt_data_in, ntt_write_address,
//            ntt_wea, ntt_data_out, ntt_finish   core memory port
//            busy, done, err                  status
// Revision : 1.0 - initial release
// ============================================================================
module ntt_poly_mem_server #(
    parameter int LOGQ       = 64,
    parameter int LOGN       = 12,
    parameter int DELAY_BRAM = 1,
    parameter int AW         = (LOGN < 9) ? 10 : LOGN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [LOGQ-1:0] s_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [LOGQ-1:0] m_data,
    output logic            m_last,
    output logic            ntt_start,
    input  logic [AW-1:0]   ntt_read_address,
    output logic [LOGQ-1:0] ntt_data_in,
    input  logic [AW-1:0]   ntt_write_address,
    input  logic            ntt_wea,
    input  logic [LOGQ-1:0] ntt_data_out,
    input  logic            ntt_finish,
    output logic            busy,
    output logic            done,
    output logic            err
);
    localparam int              N         = 1 << LOGN;
    localparam logic [LOGN:0]   N_CNT     = {1'b1, {LOGN{1'b0}}};
    localparam logic [LOGN-1:0] LAST_ADDR = {LOGN{1'b1}};

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_UNLOAD = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [LOGQ-1:0] inbuf  [N];
    logic [LOGQ-1:0] outbuf [N];

    logic [LOGN-1:0] ld_cnt_q;
    logic            ready_q;
    logic [LOGN:0]   wr_cnt_q;
    logic            fin_prev_q;
    logic            err_q;
    logic            done_q;
    logic [LOGN:0]   iss_cnt_q;
    logic            rd_vld_q;
    logic            rd_last_q;
    logic [LOGQ-1:0] rd_data_q;
    logic [LOGQ-1:0] fifo_data_q [2];
    logic [1:0]      fifo_last_q;
    logic            fifo_rd_q;
    logic            fifo_wr_q;
    logic [1:0]      fifo_cnt_q;
    logic [LOGQ-1:0] core_rd_q;

    logic            w_ld_fire;
    logic            w_ld_last;
    logic            w_run_entry;
    logic            w_wr_fire;
    logic [LOGN:0]   w_wr_cnt_next;
    logic            w_fin_edge;
    logic            w_m_fire;
    logic            w_m_last_fire;
    logic [2:0]      w_occ;
    logic            w_issue;

    // ------------------------------------------------------------------------
    // Handshakes and events
    // ------------------------------------------------------------------------
    assign w_ld_fire     = s_valid && ready_q && (state_q == ST_LOAD);
    assign w_ld_last     = w_ld_fire && (ld_cnt_q == LAST_ADDR);
    assign w_run_entry   = w_ld_last;
    assign w_wr_fire     = ntt_wea && (state_q == ST_RUN);
    // The write in the current cycle is counted before the finish-edge check.
    assign w_wr_cnt_next = (w_wr_fire && (wr_cnt_q != N_CNT)) ? wr_cnt_q + 1'b1 : wr_cnt_q;
    assign w_fin_edge    = ntt_finish && !fin_prev_q && (state_q == ST_RUN);
    assign w_m_fire      = m_valid && m_ready;
    assign w_m_last_fire = w_m_fire && m_last;

    // Words held in the skid FIFO plus the one outbuf read in flight, after
    // this cycle's pop. A new read is issued only while that stays below 2,
    // so a push can never overflow the two entries.
    assign w_occ   = {1'b0, fifo_cnt_q} + {2'b00, rd_vld_q} - {2'b00, w_m_fire};
    assign w_issue = (state_q == ST_UNLOAD) && (iss_cnt_q != N_CNT) && (w_occ < 3'd2);

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:   if (w_ld_last)     state_d = ST_RUN;
            ST_RUN:    if (w_fin_edge)    state_d = ST_UNLOAD;
            ST_UNLOAD: if (w_m_last_fire) state_d = ST_LOAD;
            default:                      state_d = ST_LOAD;
        endcase
    end

    // ------------------------------------------------------------------------
    // Counters, flags and unload skid FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_cnt_q       <= '0;
            ready_q        <= 1'b0;
            wr_cnt_q       <= '0;
            fin_prev_q     <= 1'b0;
            err_q          <= 1'b0;
            done_q         <= 1'b0;
            iss_cnt_q      <= '0;
            rd_vld_q       <= 1'b0;
            rd_last_q      <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            fifo_rd_q      <= 1'b0;
            fifo_wr_q      <= 1'b0;
            fifo_cnt_q     <= '0;
        end else begin
            // Registered so s_ready stays low until the first clock after reset.
            ready_q    <= (state_d == ST_LOAD);
            fin_prev_q <= ntt_finish;
            done_q     <= w_m_last_fire;

            if (w_ld_fire) begin
                ld_cnt_q <= w_ld_last ? '0 : ld_cnt_q + 1'b1;
            end

            if (w_run_entry) begin
                wr_cnt_q <= '0;
                err_q    <= 1'b0;
            end else if (state_q == ST_RUN) begin
                wr_cnt_q <= w_wr_cnt_next;
                if (w_fin_edge) begin
                    err_q <= (w_wr_cnt_next != N_CNT);
                end
            end

            rd_vld_q  <= w_issue;
            rd_last_q <= w_issue && (iss_cnt_q[LOGN-1:0] == LAST_ADDR);

            if (rd_vld_q) begin
                fifo_data_q[fifo_wr_q] <= rd_data_q;
                fifo_last_q[fifo_wr_q] <= rd_last_q;
                fifo_wr_q              <= ~fifo_wr_q;
            end
            if (w_m_fire) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
            fifo_cnt_q <= fifo_cnt_q + {1'b0, rd_vld_q} - {1'b0, w_m_fire};

            if (w_m_last_fire) begin
                iss_cnt_q  <= '0;
                fifo_rd_q  <= 1'b0;
                fifo_wr_q  <= 1'b0;
                fifo_cnt_q <= '0;
            end else if (w_issue) begin
                iss_cnt_q <= iss_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage arrays (contents survive reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_ld_fire) begin
            inbuf[ld_cnt_q] <= s_data;
        end
        if (w_wr_fire) begin
            outbuf[ntt_write_address[LOGN-1:0]] <= ntt_data_out;
        end
        rd_data_q <= outbuf[iss_cnt_q[LOGN-1:0]];
    end

    // Core read path, served in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_rd_q <= '0;
        end else begin
            core_rd_q <= inbuf[ntt_read_address[LOGN-1:0]];
        end
    end

    generate
        if (DELAY_BRAM == 2) begin : g_rd_lat2
            logic [LOGQ-1:0] core_rd2_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    core_rd2_q <= '0;
                end else begin
                    core_rd2_q <= core_rd_q;
                end
            end
            assign ntt_data_in = core_rd2_q;
        end else begin : g_rd_lat1
            assign ntt_data_in = core_rd_q;
        end

        if (AW > LOGN) begin : g_addr_pad
            // Address bits above LOGN carry no meaning for this buffer depth.
            logic unused_addr_bits;
            assign unused_addr_bits = ^{ntt_read_address[AW-1:LOGN], ntt_write_address[AW-1:LOGN]};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign s_ready   = ready_q;
    assign m_valid   = (fifo_cnt_q != 2'd0);
    assign m_data    = fifo_data_q[fifo_rd_q];
    assign m_last    = m_valid && fifo_last_q[fifo_rd_q];
    assign ntt_start = (state_q == ST_RUN);
    assign busy      = (state_q != ST_LOAD);
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ntt_poly_mem_server.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ntt_poly_mem_server
// Purpose  : Directed self-checking bench for ntt_poly_mem_server. The bench
//            plays host and NTT core; a scoreboard array tracks the expected
//            outbuf contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ntt_poly_mem_server;
    localparam int N     = 4096;
    localparam int N2    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        s_valid, s_ready;
    logic [63:0] s_data;
    logic        m_valid, m_ready, m_last;
    logic [63:0] m_data;
    logic        ntt_start;
    logic [11:0] ntt_read_address, ntt_write_address;
    logic [63:0] ntt_data_in, ntt_data_out;
    logic        ntt_wea, ntt_finish;
    logic        busy, done, err;

    // Small second instance: LOGN=4 (AW=10), DELAY_BRAM=2
    logic        d2_s_valid, d2_s_ready, d2_m_valid, d2_m_last, d2_start;
    logic [15:0] d2_s_data, d2_m_data, d2_din;
    logic [9:0]  d2_raddr;
    logic        d2_busy, d2_done, d2_err;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_out [N];

    ntt_poly_mem_server #(.LOGQ(64), .LOGN(12), .DELAY_BRAM(1)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .ntt_start(ntt_start), .ntt_read_address(ntt_read_address),
        .ntt_data_in(ntt_data_in), .ntt_write_address(ntt_write_address),
        .ntt_wea(ntt_wea), .ntt_data_out(ntt_data_out), .ntt_finish(ntt_finish),
        .busy(busy), .done(done), .err(err)
    );

    ntt_poly_mem_server #(.LOGQ(16), .LOGN(4), .DELAY_BRAM(2)) dut2 (
        .clk(clk), .rst(rst),
        .s_valid(d2_s_valid), .s_ready(d2_s_ready), .s_data(d2_s_data),
        .m_valid(d2_m_valid), .m_ready(1'b0), .m_data(d2_m_data), .m_last(d2_m_last),
        .ntt_start(d2_start), .ntt_read_address(d2_raddr),
        .ntt_data_in(d2_din), .ntt_write_address(10'd0),
        .ntt_wea(1'b0), .ntt_data_out(16'd0), .ntt_finish(1'b0),
        .busy(d2_busy), .done(d2_done), .err(d2_err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, observed timeout required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] perm(input int i);
        return 12'((i * 1237 + 99) % 4096);
    endfunction

    function automatic logic [63:0] fval(input int sel, input int i);
        logic [63:0] v;
        v = 64'(i);
        case (sel)
            0:       return v;
            1:       return v ^ 64'hABCD_0000_0000_0000;
            2:       return v * 3 + 7;
            default: return ~v;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 ns after a rising edge.
    task automatic load(input int sel);
        int   cnt   = 0;
        int   guard = 0;
        logic hs;
        s_valid = 1'b1;
        s_data  = fval(sel, 0);
        while (cnt < N && guard < 2 * N) begin
            @(negedge clk);
            hs = s_ready;
            if (cnt == N - 1) chk("start_before_last_load", 64'(ntt_start), 64'd0);
            @(posedge clk); #1;
            if (hs) begin
                cnt++;
                s_data = fval(sel, cnt);
            end
            guard++;
        end
        s_valid = 1'b0;
        chk("load_handshakes", 64'(cnt), 64'(N));
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [63:0] exp);
        ntt_read_address = a;
        @(posedge clk);
        @(negedge clk);
        chk(tag, ntt_data_in, exp);
        @(posedge clk); #1;
    endtask

    // fin_mode: 0 = no finish, 1 = finish one cycle after last write,
    //           2 = finish together with last write
    task automatic run_core(input int nw, input logic [63:0] x, input int fin_mode);
        for (int i = 0; i < nw; i++) begin
            logic [11:0] a;
            a                 = perm(i);
            ntt_wea           = 1'b1;
            ntt_write_address = a;
            ntt_data_out      = {52'd0, a} ^ x;
            exp_out[a]        = {52'd0, a} ^ x;
            if (fin_mode == 2 && i == nw - 1) ntt_finish = 1'b1;
            @(posedge clk); #1;
        end
        ntt_wea = 1'b0;
        if (fin_mode == 1) begin
            ntt_finish = 1'b1;
            @(posedge clk); #1;
        end
        ntt_finish = 1'b0;
    endtask

    task automatic unload(input bit bp, input string nm);
        int          idx        = 0;
        int          cyc        = 0;
        int          first      = 0;
        int          done_early = 0;
        bit          stall      = 1'b0;
        logic [63:0] sd         = '0;
        logic        sl         = 1'b0;
        while (idx < N && cyc < 4 * N + 20) begin
            cyc++;
            m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (done) done_early++;
            if (m_valid && first == 0) first = cyc;
            if (stall) begin
                chk({nm, "_stall_valid"}, 64'(m_valid), 64'd1);
                chk({nm, "_stall_data"}, m_data, sd);
                chk({nm, "_stall_last"}, 64'(m_last), 64'(sl));
            end
            stall = m_valid && !m_ready;
            sd    = m_data;
            sl    = m_last;
            if (m_valid && m_ready) begin
                chk({nm, "_data"}, m_data, exp_out[idx]);
                chk({nm, "_last"}, 64'(m_last), 64'(idx == N - 1));
                idx++;
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b0;
        chk({nm, "_words"}, 64'(idx), 64'(N));
        chk({nm, "_first_latency_ok"}, 64'(first >= 1 && first <= 2), 64'd1);
        chk({nm, "_done_early"}, 64'(done_early), 64'd0);
        @(negedge clk);
        chk({nm, "_done_pulse"}, 64'(done), 64'd1);
        chk({nm, "_busy_after"}, 64'(busy), 64'd0);
        chk({nm, "_ready_after"}, 64'(s_ready), 64'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, 64'(done), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic d2_test();
        int   cnt   = 0;
        int   guard = 0;
        logic hs;
        d2_s_valid = 1'b1;
        d2_s_data  = 16'd1;
        while (cnt < N2 && guard < 40) begin
            @(negedge clk);
            hs = d2_s_ready;
            @(posedge clk); #1;
            if (hs) begin
                cnt++;
                d2_s_data = 16'(cnt * 3 + 1);
            end
            guard++;
        end
        d2_s_valid = 1'b0;
        chk("d2_load_handshakes", 64'(cnt), 64'(N2));
        @(negedge clk);
        chk("d2_start", 64'(d2_start), 64'd1);
        @(posedge clk); #1;
        d2_raddr = 10'h3F5;    // upper bits ignored -> word 5
        @(posedge clk); @(negedge clk);
        chk("d2_lat_not_yet_5", 64'(d2_din), 64'd1);
        @(posedge clk); @(negedge clk);
        chk("d2_lat2_addr5", 64'(d2_din), 64'd16);
        @(posedge clk); #1;
        d2_raddr = 10'h00F;
        @(posedge clk); @(negedge clk);
        chk("d2_lat_not_yet_15", 64'(d2_din), 64'd16);
        @(posedge clk); @(negedge clk);
        chk("d2_lat2_addr15", 64'(d2_din), 64'd46);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        ntt_read_address = '0; ntt_write_address = '0; ntt_wea = 1'b0;
        ntt_data_out = '0; ntt_finish = 1'b0;
        d2_s_valid = 1'b0; d2_s_data = '0; d2_raddr = '0;
        for (int i = 0; i < N; i++) exp_out[i] = '0;

        // ---------------- reset values ----------------
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_start", 64'(ntt_start), 64'd0);
        chk("rst_data_in", ntt_data_in, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_d2_data_in", 64'(d2_din), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("s_ready_before_first_clk", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("s_ready_after_release", 64'(s_ready), 64'd1);
        @(posedge clk); #1;

        d2_test();

        // ---------------- run A: full run, finish with last write ----------------
        load(0);
        @(negedge clk);
        chk("a_s_ready_drop", 64'(s_ready), 64'd0);
        chk("a_start", 64'(ntt_start), 64'd1);
        chk("a_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        rd_chk("a_rd5", 12'd5, 64'd5);
        rd_chk("a_rd4095", 12'd4095, 64'd4095);
        run_core(N, 64'hA5, 2);
        @(negedge clk);
        chk("a_start_off", 64'(ntt_start), 64'd0);
        chk("a_busy_unload", 64'(busy), 64'd1);
        chk("a_err", 64'(err), 64'd0);
        @(posedge clk); #1;
        unload(1'b0, "a");

        // ---------------- stray core events in LOAD ----------------
        ntt_wea = 1'b1; ntt_write_address = perm(4050);
        ntt_data_out = 64'hDEAD_BEEF; ntt_finish = 1'b1;
        @(posedge clk); #1;
        ntt_wea = 1'b0; ntt_finish = 1'b0;
        @(negedge clk);
        chk("stray_start", 64'(ntt_start), 64'd0);
        chk("stray_busy", 64'(busy), 64'd0);
        chk("stray_ready", 64'(s_ready), 64'd1);
        @(posedge clk); #1;

        // ---------------- run B: short run, backpressured unload ----------------
        load(1);
        @(negedge clk);
        chk("b_start", 64'(ntt_start), 64'd1);
        @(posedge clk); #1;
        rd_chk("b_rd0", 12'd0, 64'hABCD_0000_0000_0000);
        run_core(4000, 64'h5A00, 1);
        @(negedge clk);
        chk("b_err_set", 64'(err), 64'd1);
        chk("b_start_off", 64'(ntt_start), 64'd0);
        @(posedge clk); #1;
        unload(1'b1, "b");
        @(negedge clk);
        chk("b_err_held_in_load", 64'(err), 64'd1);
        @(posedge clk); #1;

        // ---------------- run C: err clear on RUN entry, reset mid-RUN ----------------
        load(2);
        @(negedge clk);
        chk("c_err_cleared", 64'(err), 64'd0);
        chk("c_start", 64'(ntt_start), 64'd1);
        @(posedge clk); #1;
        rd_chk("c_rd5", 12'd5, 64'd22);
        run_core(100, 64'h77, 0);
        rst = 1'b0;
        #1;
        chk("c_rst_start", 64'(ntt_start), 64'd0);
        chk("c_rst_busy", 64'(busy), 64'd0);
        chk("c_rst_ready", 64'(s_ready), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("c_ready_before_clk", 64'(s_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("c_ready_after", 64'(s_ready), 64'd1);
        chk("c_start_after", 64'(ntt_start), 64'd0);
        @(posedge clk); #1;

        // ---------------- run D: normal operation after reset ----------------
        load(3);
        @(negedge clk);
        chk("d_start", 64'(ntt_start), 64'd1);
        @(posedge clk); #1;
        rd_chk("d_rd5", 12'd5, ~64'd5);
        rd_chk("d_rd4095", 12'd4095, ~64'd4095);
        run_core(N, 64'h3C3C, 1);
        @(negedge clk);
        chk("d_err", 64'(err), 64'd0);
        chk("d_start_off", 64'(ntt_start), 64'd0);
        @(posedge clk); #1;
        unload(1'b0, "d");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
